// File: rtl/exe_mem_req_pkg.sv
// Shared bus definitions for the EXE-stage memory request path: size encodings,
// alignment rules and the field layout of an outstanding-queue entry.
package exe_mem_req_pkg;

  typedef enum logic [1:0] {
    SzByte  = 2'd0,
    SzHalf  = 2'd1,
    SzWord  = 2'd2,
    SzDword = 2'd3
  } mem_size_e;

  // Queue entry layout, MSB first: {wr, size, unsigned, off, tag}. The cancel bit
  // lives beside the entry inside the queue so a flush can set it in place.
  localparam int unsigned ENT_WR_W   = 1;
  localparam int unsigned ENT_SIZE_W = 2;
  localparam int unsigned ENT_UNS_W  = 1;
  localparam int unsigned ENT_OFF_W  = 3;
  localparam int unsigned ENT_BASE_W = ENT_WR_W + ENT_SIZE_W + ENT_UNS_W + ENT_OFF_W;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input mem_size_e sz);
    logic [2:0] m;
    case (sz)
      SzByte:  m = 3'b000;
      SzHalf:  m = 3'b001;
      SzWord:  m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  // A dword access on a 32-bit bus can never be served, so it counts as misaligned.
  function automatic logic misaligned(input mem_size_e sz, input logic [2:0] addr_lo,
                                      input logic bus64);
    return ((addr_lo & align_mask(sz)) != 3'b000) || ((sz == SzDword) && !bus64);
  endfunction

endpackage

// File: rtl/mem_req_queue.sv
// Circular queue of outstanding bus requests with a per-entry cancel bit that a
// flush sets on every slot at once.
module mem_req_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_cancel,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_cancel,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] cancel_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Guard push/pop against overflow and underflow.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count   = count_q;
    pop_data   = mem_q[rd_ptr_q];
    pop_cancel = cancel_q[rd_ptr_q];
  end

  // Pointers, occupancy and cancel bits; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cancel_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (flush) cancel_q <= '1;
      // The pushed entry's own cancel wins over the blanket flush set above.
      if (do_push) cancel_q[wr_ptr_q] <= push_cancel;
    end
  end

  // Entry payload storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/exe_mem_req.sv
// EXE-stage memory request unit: accepts load/store requests, drives an SRAM-like
// bus one request at a time, tracks outstanding requests and returns load data.
module exe_mem_req
  import exe_mem_req_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned TAG_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_wr,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [31:0]         in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                flush,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [31:0]         addr,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [TAG_W-1:0]    resp_tag,
  output logic                ale_valid,
  output logic [31:0]         ale_addr
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned ENT_W  = ENT_BASE_W + TAG_W;
  localparam int unsigned CNT_W  = $clog2(MAX_OUT) + 1;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e              state_q, state_d;
  logic                wr_q, uns_q, cancel_q;
  logic [1:0]          size_q;
  logic [31:0]         addr_q;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [TAG_W-1:0]    tag_q;
  logic                resp_valid_q, ale_valid_q;
  logic [DATA_W-1:0]   resp_data_q, resp_ext;
  logic [TAG_W-1:0]    resp_tag_q;
  logic [31:0]         ale_addr_q;

  logic                accept, is_mis, accept_ok, accept_mis;
  logic [OFF_W-1:0]    in_off;
  logic                q_push, q_pop, q_pop_cancel, q_full, q_empty;
  logic [ENT_W-1:0]    q_push_data, q_pop_data;
  logic [CNT_W-1:0]    q_count;
  logic                e_wr, e_uns;
  logic [1:0]          e_size;
  logic [2:0]          e_off;
  logic [TAG_W-1:0]    e_tag;
  logic                resp_fire;

  // Request acceptance and misalignment classification.
  always_comb begin
    in_ready   = (state_q == StIdle) && (q_count < CNT_W'(MAX_OUT)) && !flush;
    accept     = in_valid && in_ready;
    is_mis     = misaligned(mem_size_e'(in_size), in_addr[2:0], DATA_W == 64);
    accept_ok  = accept && !is_mis;
    accept_mis = accept && is_mis;
    in_off     = in_addr[OFF_W-1:0];
  end

  // Byte strobes and replicated store data for the accepted request.
  always_comb begin
    wstrb_d = '0;
    wdata_d = '0;
    if (in_wr) begin
      case (mem_size_e'(in_size))
        SzByte:  wstrb_d = STRB_W'(1) << in_off;
        SzHalf:  wstrb_d = STRB_W'(2'b11) << in_off;
        SzWord:  wstrb_d = STRB_W'(4'hF) << in_off;
        default: wstrb_d = '1;
      endcase
    end
    for (int i = 0; i < STRB_W; i++) begin
      int j;
      case (mem_size_e'(in_size))
        SzByte:  j = 0;
        SzHalf:  j = i % 2;
        SzWord:  j = i % 4;
        default: j = i % 8;
      endcase
      wdata_d[8*i +: 8] = in_wdata[8*j +: 8];
    end
  end

  // Issue FSM next state: hold in StReq until the bus takes the address.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept_ok) state_d = StReq;
      StReq:   if (addr_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register and the registered bus request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      tag_q    <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_ok) begin
        wr_q     <= in_wr;
        size_q   <= in_size;
        uns_q    <= in_unsigned;
        addr_q   <= in_addr;
        wstrb_q  <= wstrb_d;
        wdata_q  <= wdata_d;
        tag_q    <= in_tag;
        cancel_q <= 1'b0;
      end else if (flush) begin
        // The in-flight request keeps driving the bus but its result is dropped.
        cancel_q <= 1'b1;
      end
    end
  end

  assign req   = (state_q == StReq);
  assign wr    = wr_q;
  assign size  = size_q;
  assign addr  = addr_q;
  assign wstrb = wstrb_q;
  assign wdata = wdata_q;

  // Queue push on address acceptance, pop on returned data.
  always_comb begin
    q_push      = req && addr_ok && (!q_full || q_pop);
    q_pop       = data_ok && !q_empty;
    q_push_data = {wr_q, size_q, uns_q, ENT_OFF_W'(addr_q[OFF_W-1:0]), tag_q};
  end

  mem_req_queue #(
    .DEPTH (MAX_OUT),
    .WIDTH (ENT_W)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (q_push),
    .push_data   (q_push_data),
    .push_cancel (cancel_q | flush),
    .pop         (q_pop),
    .flush       (flush),
    .pop_data    (q_pop_data),
    .pop_cancel  (q_pop_cancel),
    .count       (q_count),
    .full        (q_full),
    .empty       (q_empty)
  );

  // Select the addressed lane of rdata and sign- or zero-extend it.
  always_comb begin
    logic [DATA_W-1:0]        lane, tmp;
    logic signed [DATA_W-1:0] stmp;
    int unsigned              bits, sh;
    {e_wr, e_size, e_uns, e_off, e_tag} = q_pop_data;
    lane = rdata >> {e_off, 3'b000};
    bits = 32'd8 << e_size;
    sh   = (bits >= DATA_W) ? 0 : DATA_W - bits;
    tmp  = lane << sh;
    stmp = tmp;
    if (e_uns) resp_ext = tmp >> sh;
    else       resp_ext = stmp >>> sh;
    resp_fire = q_pop && !e_wr && !q_pop_cancel && !flush;
  end

  // Registered load response and misalignment pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      ale_valid_q  <= 1'b0;
      ale_addr_q   <= '0;
    end else begin
      resp_valid_q <= resp_fire;
      if (resp_fire) begin
        resp_data_q <= resp_ext;
        resp_tag_q  <= e_tag;
      end
      ale_valid_q <= accept_mis && !flush;
      if (accept_mis) ale_addr_q <= in_addr;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;
  assign ale_valid  = ale_valid_q;
  assign ale_addr   = ale_addr_q;

endmodule
